// File: rtl/drum_result_expander_pkg.sv
// Shared DRUM datapath constants: default operand/mantissa/shift widths and the max-shift helper.
// The truncation front end imports the same package so both ends agree on widths.
package drum_result_expander_pkg;

   localparam int unsigned DrumN  = 8;
   localparam int unsigned DrumK  = 4;
   localparam int unsigned DrumSw = 3;

   localparam int unsigned DrumPw    = 2 * DrumK;
   localparam int unsigned DrumRw    = 2 * DrumN;
   localparam int unsigned DrumMaxSh = DrumN - DrumK;

   function automatic int unsigned drum_max_shift(input int unsigned n, input int unsigned k);
      return n - k;
   endfunction

endpackage

// File: rtl/drum_barrel_shifter.sv
// Combinational logarithmic left shifter: zero-extends a PW-bit value to RW bits and shifts it
// left by i_shift, one mux stage per shift bit.
module drum_barrel_shifter #(
   parameter int unsigned PW  = 8,
   parameter int unsigned SHW = 4,
   parameter int unsigned RW  = 16
) (
   input  logic [PW-1:0]  i_data,
   input  logic [SHW-1:0] i_shift,
   output logic [RW-1:0]  o_data
);

   logic [RW-1:0] w_stage [0:SHW];

   assign w_stage[0] = RW'(i_data);

   for (genvar s = 0; s < SHW; s++) begin : g_stage
      assign w_stage[s+1] = i_shift[s] ? (w_stage[s] << (2 ** s)) : w_stage[s];
   end

   assign o_data = w_stage[SHW];

endmodule

// File: rtl/drum_result_expander.sv
// DRUM back end: two-stage back-pressured pipeline that shifts the KxK mantissa product back
// to a 2N-bit result. Define DRUM_EXPANDER_RANGE_CHECK_EN to flag and zero out-of-range shifts.
module drum_result_expander
   import drum_result_expander_pkg::*;
#(
   parameter int unsigned N  = DrumN,
   parameter int unsigned K  = DrumK,
   parameter int unsigned SW = DrumSw
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*K-1:0]    in_prod,
   input  logic [SW-1:0]     in_sh_a,
   input  logic [SW-1:0]     in_sh_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*N-1:0]    out_result,
   output logic              out_err
);

   localparam int unsigned PW    = 2 * K;
   localparam int unsigned RW    = 2 * N;
   localparam int unsigned MaxSh = drum_max_shift(N, K);

   logic          w_s1_adv;
   logic          w_s2_adv;
   logic [SW:0]   w_sh_sum;
   logic [RW-1:0] w_shifted;
   logic [RW-1:0] w_s2_result_d;

   logic          r_s1_valid;
   logic [PW-1:0] r_s1_prod;
   logic [SW:0]   r_s1_sh_sum;
   logic          r_s2_valid;
   logic [RW-1:0] r_s2_result;

   // The only combinational input-to-output path: out_ready -> in_ready.
   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   assign w_sh_sum = {1'b0, in_sh_a} + {1'b0, in_sh_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_prod   <= '0;
         r_s1_sh_sum <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_prod   <= in_prod;
            r_s1_sh_sum <= w_sh_sum;
         end
      end
   end

   drum_barrel_shifter #(
      .PW  (PW),
      .SHW (SW + 1),
      .RW  (RW)
   ) u_shifter (
      .i_data  (r_s1_prod),
      .i_shift (r_s1_sh_sum),
      .o_data  (w_shifted)
   );

`ifdef DRUM_EXPANDER_RANGE_CHECK_EN
   logic w_bad;
   logic r_s1_bad;
   logic r_s2_err;

   assign w_bad = (in_sh_a > SW'(MaxSh)) || (in_sh_b > SW'(MaxSh));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_bad <= 1'b0;
         r_s2_err <= 1'b0;
      end else begin
         if (w_s1_adv && in_valid) begin
            r_s1_bad <= w_bad;
         end
         if (w_s2_adv && r_s1_valid) begin
            r_s2_err <= r_s1_bad;
         end
      end
   end

   assign w_s2_result_d = r_s1_bad ? '0 : w_shifted;
   assign out_err       = r_s2_err;
`else
   assign w_s2_result_d = w_shifted;
   assign out_err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_result <= w_s2_result_d;
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign out_result = r_s2_result;

endmodule

// File: tb/tb_drum_result_expander.sv
// Scoreboard bench for drum_result_expander (N=8, K=4, SW=3): expected results are queued at
// input acceptance and compared at each output transfer.
module tb_drum_result_expander;

   typedef struct {
      logic [15:0] res;
      logic        err;
      int          acc;
      bit          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_prod;
   logic [2:0]  in_sh_a;
   logic [2:0]  in_sh_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_err;

   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   bit   lat_flag = 1'b0;
   bit   rand_done;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   drum_result_expander #(
      .N  (8),
      .K  (4),
      .SW (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_prod    (in_prod),
      .in_sh_a    (in_sh_a),
      .in_sh_b    (in_sh_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [7:0] p, input logic [2:0] a, input logic [2:0] b);
      exp_t        e;
      logic [4:0]  sum;
      logic        bad;
      sum = {2'b00, a} + {2'b00, b};
      bad = (a > 3'd4) || (b > 3'd4);
      e.res = {8'h00, p} << sum;
      e.err = 1'b0;
`ifdef DRUM_EXPANDER_RANGE_CHECK_EN
      if (bad) e.res = 16'h0000;
      e.err = bad;
`else
      if (bad) e.err = 1'b0;
`endif
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   // Handshakes are sampled mid-cycle, where values equal those at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_out", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("result", 32'(out_result), 32'(e.res));
               chk("err", 32'(out_err), 32'(e.err));
               if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
            end
         end
         if (in_valid && in_ready) begin
            e     = model(in_prod, in_sh_a, in_sh_b);
            e.acc = cyc;
            e.lat = lat_flag;
            sb.push_back(e);
         end
      end
   end

   task automatic send(input logic [7:0] p, input logic [2:0] a, input logic [2:0] b,
                       input bit lat);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_prod  = p;
      in_sh_a  = a;
      in_sh_b  = b;
      lat_flag = lat;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] held;
      exp_t        e0;

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_prod   = 8'hFF;
      in_sh_a   = 3'd1;
      in_sh_b   = 3'd1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'h0000);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases, one at a time with latency checked.
      send(8'h8F, 3'd4, 3'd3, 1'b1);
      drain();
      send(8'hE1, 3'd4, 3'd4, 1'b1);
      drain();
      send(8'h2D, 3'd0, 3'd0, 1'b1);
      drain();
      send(8'h00, 3'd4, 3'd4, 1'b1);
      drain();
      send(8'h11, 3'd5, 3'd0, 1'b1);
      drain();
      send(8'h8F, 3'd7, 3'd7, 1'b1);
      drain();

      // Back-pressure: out_ready low while four transactions stream in.
      e0        = model(8'hA5, 3'd1, 3'd2);
      out_ready = 1'b0;
      fork
         begin
            send(8'hA5, 3'd1, 3'd2, 1'b0);
            send(8'h3C, 3'd2, 3'd2, 1'b0);
            send(8'h7E, 3'd4, 3'd0, 1'b0);
            send(8'hC3, 3'd3, 3'd1, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_head", 32'(out_result), 32'(e0.res));
            held = out_result;
            @(negedge clk);
            chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
            chk("bp_stable", 32'(out_result), 32'(held));
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Mid-operation reset discards the in-flight transaction.
      send(8'h55, 3'd2, 3'd1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_rst_idle", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Random traffic with random back-pressure.
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 1'b0);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
